// File: rtl/bp_mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
//   port_e       : which core port owns a request/response
//   resp_meta_t  : per-slot metadata carried down the response pipe
//   strb2mask()  : expands byte strobes into a per-bit write mask
package bp_mem_arb_pkg;

  typedef enum logic {
    PortData  = 1'b0,
    PortInstr = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
  } resp_meta_t;

  // Widest strobe the helper supports; callers zero-extend and truncate.
  localparam int MaxStrbWidth = 64;
  localparam int MaxDataWidth = MaxStrbWidth * 8;

  function automatic logic [MaxDataWidth-1:0] strb2mask(input logic [MaxStrbWidth-1:0] strb);
    logic [MaxDataWidth-1:0] mask;
    mask = '0;
    for (int i = 0; i < MaxStrbWidth; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/bp_mem_arb_resp_pipe.sv
// Response metadata delay line. Each granted request enters as one entry and
// leaves exactly Depth cycles later, lined up with the SRAM read data.
// Ports:
//   clk    in   clock
//   rst_n  in   async active-low reset; clears every in-flight entry at once
//   push   in   metadata for the request granted this cycle (valid=0 if none)
//   head   out  metadata whose response is due this cycle
module bp_mem_arb_resp_pipe
  import bp_mem_arb_pkg::*;
#(
  parameter int Depth = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  resp_meta_t push,
  output resp_meta_t head
);

  resp_meta_t stage_q [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= push;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign head = stage_q[Depth-1];

endmodule

// File: rtl/bp_mem_arbiter.sv
// Merges the core's instruction and data memory ports onto one shared SRAM.
// Same-cycle grant with round-robin on conflicts, byte-to-word address
// translation with range check, strobe-to-bitmask expansion, and a per-port
// response (valid/err/rdata) returned SramLatency cycles after the grant.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   instr_* / data_*              core ports: req/gnt, byte addr, wdata, strb,
//                                 we, rdata, rvalid, err
//   sram_req_o/we_o/addr_o        SRAM command (word address)
//   sram_wdata_o/wmask_o          SRAM write data and per-bit mask
//   sram_rdata_i                  SRAM read data, SramLatency cycles after req
module bp_mem_arbiter
  import bp_mem_arb_pkg::*;
#(
  parameter int                   AddrWidth   = 64,
  parameter int                   DataWidth   = 64,
  parameter int                   NumWords    = 1 << 17,
  parameter logic [AddrWidth-1:0] BaseAddr    = '0,
  parameter int                   SramLatency = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,

  input  logic                         instr_req_i,
  output logic                         instr_gnt_o,
  input  logic [AddrWidth-1:0]         instr_addr_i,
  input  logic [DataWidth-1:0]         instr_wdata_i,
  input  logic [DataWidth/8-1:0]       instr_strb_i,
  input  logic                         instr_we_i,
  output logic [DataWidth-1:0]         instr_rdata_o,
  output logic                         instr_rvalid_o,
  output logic                         instr_err_o,

  input  logic                         data_req_i,
  output logic                         data_gnt_o,
  input  logic [AddrWidth-1:0]         data_addr_i,
  input  logic [DataWidth-1:0]         data_wdata_i,
  input  logic [DataWidth/8-1:0]       data_strb_i,
  input  logic                         data_we_i,
  output logic [DataWidth-1:0]         data_rdata_o,
  output logic                         data_rvalid_o,
  output logic                         data_err_o,

  output logic                         sram_req_o,
  output logic                         sram_we_o,
  output logic [$clog2(NumWords)-1:0]  sram_addr_o,
  output logic [DataWidth-1:0]         sram_wdata_o,
  output logic [DataWidth-1:0]         sram_wmask_o,
  input  logic [DataWidth-1:0]         sram_rdata_i
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int SramAw    = $clog2(NumWords);
  localparam int OffShift  = $clog2(StrbWidth);
  // One extra bit so a map that fills the whole address space still compares.
  localparam logic [AddrWidth:0] RangeBytes = (AddrWidth+1)'(NumWords) << OffShift;

  // rr_q names the port that wins the next conflict.
  port_e rr_q;

  logic                 conflict;
  logic                 gnt_instr;
  logic                 gnt_data;
  logic                 any_gnt;
  logic                 in_range;
  logic                 issue;
  logic [AddrWidth-1:0] sel_addr;
  logic [AddrWidth-1:0] offset;
  logic [DataWidth-1:0] sel_wdata;
  logic [StrbWidth-1:0] sel_strb;
  logic                 sel_we;
  logic [DataWidth-1:0] sel_mask;

  resp_meta_t           push_meta;
  resp_meta_t           head_meta;

  // Arbitration
  assign conflict = instr_req_i & data_req_i;

  always_comb begin
    gnt_data  = 1'b0;
    gnt_instr = 1'b0;
    if (conflict) begin
      if (rr_q == PortData) gnt_data  = 1'b1;
      else                  gnt_instr = 1'b1;
    end else begin
      gnt_data  = data_req_i;
      gnt_instr = instr_req_i;
    end
  end

  assign any_gnt     = gnt_data | gnt_instr;
  assign instr_gnt_o = gnt_instr;
  assign data_gnt_o  = gnt_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= PortData;
    end else if (conflict) begin
      rr_q <= (rr_q == PortData) ? PortInstr : PortData;
    end
  end

  // Request mux, range check and address translation
  always_comb begin
    sel_addr  = gnt_instr ? instr_addr_i  : data_addr_i;
    sel_wdata = gnt_instr ? instr_wdata_i : data_wdata_i;
    sel_strb  = gnt_instr ? instr_strb_i  : data_strb_i;
    sel_we    = gnt_instr ? instr_we_i    : data_we_i;
  end

  assign offset   = sel_addr - BaseAddr;
  assign in_range = {1'b0, offset} < RangeBytes;
  assign issue    = any_gnt & in_range;
  assign sel_mask = DataWidth'(strb2mask(MaxStrbWidth'(sel_strb)));

  // Nothing reaches the SRAM bus unless a granted request is in range.
  always_comb begin
    sram_req_o   = issue;
    sram_we_o    = issue & sel_we;
    sram_addr_o  = issue ? SramAw'(offset >> OffShift) : '0;
    sram_wdata_o = issue ? sel_wdata : '0;
    sram_wmask_o = (issue && sel_we) ? sel_mask : '0;
  end

  // Response pipe: out-of-range requests still travel it so they get answered.
  always_comb begin
    push_meta       = '0;
    push_meta.valid = any_gnt;
    push_meta.port  = gnt_instr ? PortInstr : PortData;
    push_meta.err   = any_gnt & ~in_range;
  end

  bp_mem_arb_resp_pipe #(
    .Depth (SramLatency)
  ) u_resp_pipe (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push_meta),
    .head  (head_meta)
  );

  always_comb begin
    instr_rvalid_o = head_meta.valid && (head_meta.port == PortInstr);
    data_rvalid_o  = head_meta.valid && (head_meta.port == PortData);
    instr_err_o    = instr_rvalid_o & head_meta.err;
    data_err_o     = data_rvalid_o  & head_meta.err;
    instr_rdata_o  = (instr_rvalid_o && !head_meta.err) ? sram_rdata_i : '0;
    data_rdata_o   = (data_rvalid_o  && !head_meta.err) ? sram_rdata_i : '0;
  end

endmodule
